// File: rtl/keypad_scan16_if.sv
// Keypad-side signal bundle for keypad_scan16: column inputs, row strobes and
// decoded key outputs. The slave modport is the scanner, the master is the keypad/host side.
interface keypad_scan16_if;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] value;
  logic        pressed;

  modport slave  (input col, output row, key_code, key_valid, value, pressed);
  modport master (output col, input row, key_code, key_valid, value, pressed);
endinterface

// File: rtl/keypad_scan16.sv
// 4x4 matrix keypad scanner with frame-based debounce and a 4-digit code history.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan16 #(
  parameter int SCAN_BITS      = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  keypad_scan16_if.slave kp
);

  localparam int         CW   = SCAN_BITS + 2;
  localparam logic [3:0] DS_W = 4'(DEBOUNCE_SCANS);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
    $error("keypad_scan16: DEBOUNCE_SCANS out of range 1..15");
  end
  if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_repeat
    $error("keypad_scan16: REPEAT_FRAMES out of range 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  function automatic logic [3:0] row_decode(input logic [1:0] r);
    case (r)
      2'd0:    row_decode = 4'b1110;
      2'd1:    row_decode = 4'b1101;
      2'd2:    row_decode = 4'b1011;
      2'd3:    row_decode = 4'b0111;
      default: row_decode = 4'b1110;
    endcase
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] v);
    low_count = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (v[0]) begin
      low_index = 2'd0;
    end else if (v[1]) begin
      low_index = 2'd1;
    end else if (v[2]) begin
      low_index = 2'd2;
    end else begin
      low_index = 2'd3;
    end
  endfunction

  logic [CW-1:0] scan_q, scan_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    sync1_q, sync2_q;
  logic          hit_q, hit_d, multi_q, multi_d;
  logic [3:0]    fkey_q, fkey_d;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d, cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [15:0]   value_q, value_d;
  logic          pressed_q, pressed_d;

  logic          sample_s, first_s, frame_end_s;
  logic [1:0]    row_idx_s;
  logic [3:0]    col_low_s;
  logic [2:0]    n_low_s;
  logic          prev_hit_s, prev_multi_s, row_single_s;
  logic          frame_hit_s, frame_multi_s, frame_none_s, frame_single_s;
  logic [3:0]    frame_key_s;
  logic          ev_s, rep_fire_s;
  logic [3:0]    ev_key_s;

  // Scan counter advance and row strobe for the upcoming cycle.
  always_comb begin
    scan_d = scan_q + {{(CW-1){1'b0}}, 1'b1};
    row_d  = row_decode(scan_d[CW-1:CW-2]);
  end

  // Per-row column analysis folded into the running frame classification.
  always_comb begin
    sample_s       = &scan_q[SCAN_BITS-1:0];
    row_idx_s      = scan_q[CW-1:CW-2];
    first_s        = (row_idx_s == 2'd0);
    frame_end_s    = sample_s && (row_idx_s == 2'd3);
    col_low_s      = ~sync2_q;
    n_low_s        = low_count(col_low_s);
    row_single_s   = (n_low_s == 3'd1);
    prev_hit_s     = first_s ? 1'b0 : hit_q;
    prev_multi_s   = first_s ? 1'b0 : multi_q;
    frame_multi_s  = prev_multi_s || (n_low_s > 3'd1) || (row_single_s && prev_hit_s);
    frame_hit_s    = prev_hit_s || row_single_s;
    frame_key_s    = (row_single_s && !prev_hit_s) ? {row_idx_s, low_index(col_low_s)} : fkey_q;
    frame_none_s   = !frame_hit_s && !frame_multi_s;
    frame_single_s = frame_hit_s && !frame_multi_s;
    if (sample_s) begin
      hit_d   = frame_hit_s;
      multi_d = frame_multi_s;
      fkey_d  = frame_key_s;
    end else begin
      hit_d   = hit_q;
      multi_d = multi_q;
      fkey_d  = fkey_q;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] RF_W = 8'(REPEAT_FRAMES);
  logic [7:0] rep_q, rep_d;

  assign rep_fire_s = frame_end_s && (state_q == S_HELD) && frame_single_s &&
                      (frame_key_s == key_code_q) && (rep_q + 8'd1 == RF_W);

  // Repeat frame counter: runs on frames holding the accepted key, clears on (re)entry to HELD.
  always_comb begin
    if (frame_end_s && (state_q == S_HELD) && frame_single_s) begin
      if (frame_key_s == key_code_q) begin
        rep_d = rep_fire_s ? 8'd0 : rep_q + 8'd1;
      end else begin
        rep_d = 8'd0;
      end
    end else if ((state_d == S_HELD) && (state_q != S_HELD)) begin
      rep_d = 8'd0;
    end else begin
      rep_d = rep_q;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= 8'd0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire_s = 1'b0;
`endif

  // Debounce FSM, evaluated only on the frame-end sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    ev_s     = 1'b0;
    ev_key_s = cand_q;
    if (frame_end_s) begin
      case (state_q)
        S_IDLE: begin
          if (frame_single_s && (DS_W == 4'd1)) begin
            ev_s     = 1'b1;
            ev_key_s = frame_key_s;
            cnt_d    = 4'd0;
            state_d  = S_HELD;
          end else if (frame_single_s) begin
            cand_d  = frame_key_s;
            cnt_d   = 4'd1;
            state_d = S_DEBOUNCE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DEBOUNCE: begin
          if (frame_single_s && (frame_key_s == cand_q)) begin
            if (cnt_q + 4'd1 == DS_W) begin
              ev_s     = 1'b1;
              ev_key_s = cand_q;
              cnt_d    = 4'd0;
              state_d  = S_HELD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (frame_single_s) begin
            cand_d = frame_key_s;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (frame_none_s && (DS_W == 4'd1)) begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else if (frame_none_s) begin
            cnt_d   = 4'd1;
            state_d = S_RELEASE;
          end else if (rep_fire_s) begin
            ev_s     = 1'b1;
            ev_key_s = key_code_q;
          end else begin
            state_d = S_HELD;
          end
        end
        S_RELEASE: begin
          if (frame_none_s && (cnt_q + 4'd1 == DS_W)) begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else if (frame_none_s) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = S_HELD;
          end
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output next-state: event pulse, code history and held flag.
  always_comb begin
    key_valid_d = ev_s;
    pressed_d   = (state_d == S_HELD) || (state_d == S_RELEASE);
    if (ev_s) begin
      key_code_d = ev_key_s;
      value_d    = {value_q[11:0], ev_key_s};
    end else begin
      key_code_d = key_code_q;
      value_d    = value_q;
    end
  end

  // State, scan and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q      <= {CW{1'b0}};
      row_q       <= 4'b1110;
      sync1_q     <= 4'd0;
      sync2_q     <= 4'd0;
      hit_q       <= 1'b0;
      multi_q     <= 1'b0;
      fkey_q      <= 4'd0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      value_q     <= 16'd0;
      pressed_q   <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      row_q       <= row_d;
      sync1_q     <= kp.col;
      sync2_q     <= sync1_q;
      hit_q       <= hit_d;
      multi_q     <= multi_d;
      fkey_q      <= fkey_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      value_q     <= value_d;
      pressed_q   <= pressed_d;
    end
  end

  assign kp.row       = row_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.value     = value_q;
  assign kp.pressed   = pressed_q;

endmodule

// File: doc/keypad_scan16.md
KEYPAD_SCAN16 -- requirements
Module: keypad_scan16

Interface
REQ-001 The block SHALL have parameter SCAN_BITS, default 16, meaning each row is strobed for 2^SCAN_BITS clk cycles.
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4, range 1..15, meaning the number of consecutive identical full scan frames needed to accept a press or a release.
REQ-003 The block SHALL have parameter REPEAT_FRAMES, default 64, range 1..255, meaning the auto-repeat period in frames; it is used only under REQ-026.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  is the asynchronous, active-low reset.
REQ-006 col  input  4  carries the keypad columns, active-low and asynchronous.
REQ-007 row  output  4  carries the row strobes, active-low with exactly one bit low.
REQ-008 key_code  output  4  is the hex code of the last accepted key.
REQ-009 key_valid  output  1  is a one-cycle pulse per accepted key event.
REQ-010 value  output  16  holds the last four accepted codes, newest in [3:0].
REQ-011 pressed  output  1  is high while a debounced key is held (states HELD and RELEASE).

Function
REQ-012 col SHALL pass through a 2-flop synchronizer before any use.
REQ-013 A free-running scan counter SHALL be used; row index r = counter[SCAN_BITS+1:SCAN_BITS], and row[r] is low.
- r=0 drives row 1110; r=3 drives row 0111.
REQ-014 The synchronized col SHALL be sampled on the last cycle of each row period, when counter[SCAN_BITS-1:0] is all ones.
REQ-015 Key code SHALL be 4*r+c when row[r] and col[c] are both low.
REQ-016 A frame is rows 0..3; at the r=3 sample the frame SHALL be classified as NONE, SINGLE(k) or MULTI.
- MULTI means more than one low column in any row, or low columns in more than one row.
REQ-017 The FSM SHALL have states IDLE, DEBOUNCE, HELD and RELEASE, and it evaluates only at frame end.
REQ-018 IDLE: on SINGLE(k), candidate=k, cnt=1, go to DEBOUNCE; otherwise stay in IDLE.
REQ-019 DEBOUNCE: same k SHALL increment cnt; a different SINGLE SHALL restart with candidate=new key and cnt=1; NONE or MULTI SHALL return to IDLE.
REQ-020 Acceptance SHALL occur when cnt reaches DEBOUNCE_SCANS.
- Actions: key_valid high for one cycle, the cycle after the frame-end sample.
- key_code<=k; value<={value[11:0],k}; go to HELD.
- With DEBOUNCE_SCANS=1, acceptance happens directly from IDLE.
REQ-021 HELD: NONE SHALL go to RELEASE with cnt=1; SINGLE or MULTI (rollover) SHALL stay in HELD with no new event.
REQ-022 RELEASE: NONE SHALL increment cnt and go to IDLE at DEBOUNCE_SCANS; SINGLE or MULTI SHALL return to HELD.
REQ-023 Shifting a fifth key SHALL discard value[15:12]; key_code and value hold between events.

Reset
REQ-024 While rst_n is low, the following SHALL be forced immediately, independent of clk:
- row=1110, key_code=0, key_valid=0, value=0, pressed=0.
- FSM=IDLE; all counters and synchronizer flops=0.
- Reset mid-debounce or mid-hold SHALL discard the candidate with no event.
REQ-025 After rst_n rises, scanning SHALL resume from r=0 on the first clk edge.

Configuration
REQ-026 With KEYPAD_REPEAT_EN defined, HELD with SINGLE(k) of the accepted k SHALL count frames.
- Every REPEAT_FRAMES frames it emits key_valid and shifts k into value.
- The count clears on entering HELD or on a different key.
- Without the macro, exactly one event per press and no repeat logic.

Verification
REQ-027 Bench SHALL use SCAN_BITS=2 (16-cycle frame) and DEBOUNCE_SCANS=2.
- Scenario: rst_n low mid-row-2 -> row=1110, value=0x0000, pressed=0 in the same cycle.
REQ-028 Hold row1/col2 for 4 frames -> exactly one key_valid, key_code=6, value=0x0006, pressed=1.
- After release -> pressed=0 after 2 empty frames.
REQ-029 Press keys 1,2,3,A with releases -> value=0x123A; then press B -> value=0x23AB.
REQ-030 Key 5 alternating present/absent every frame for 8 frames -> no key_valid; FSM never leaves IDLE/DEBOUNCE.
REQ-031 Keys 0 and 5 held together 6 frames -> no key_valid, value unchanged.
REQ-032 REPEAT_FRAMES=3, hold key F 10 frames past acceptance -> 4 pulses with KEYPAD_REPEAT_EN, 1 pulse without.
